// File: rtl/lcd_bus_writer.sv
// 8080-style parallel LCD writer: runs the panel hardware-reset sequence, then
// drains a show-ahead command FIFO one word per write strobe.
module lcd_bus_writer #(
    parameter int WR_LOW_CYC   = 2,
    parameter int WR_HIGH_CYC  = 2,
    parameter int RST_LOW_CYC  = 500000,
    parameter int RST_WAIT_CYC = 6000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rempty,
    input  logic [16:0] rdata,
    output logic        rinc,
    output logic        lcd_rst_n,
    output logic        lcd_cs_n,
    output logic        lcd_rs,
    output logic        lcd_wr_n,
    output logic        lcd_rd_n,
    output logic [15:0] lcd_db,
    output logic        lcd_ready,
    output logic        busy
);

    typedef enum logic [2:0] {
        RST_LO,
        RST_WAIT,
        IDLE,
        WR_LO,
        WR_HI
    } state_t;

    localparam logic [23:0] RST_LO_LAST   = 24'(RST_LOW_CYC - 1);
    localparam logic [23:0] RST_WAIT_LAST = 24'(RST_WAIT_CYC - 1);
    localparam logic [23:0] WR_LO_LAST    = 24'(WR_LOW_CYC - 1);
    localparam logic [23:0] WR_HI_LAST    = 24'(WR_HIGH_CYC - 1);

    state_t      state;
    logic [23:0] cnt;

    // The pop is taken in the same cycle the word is latched onto the bus.
    assign rinc     = rst_n && (state == IDLE) && !rempty;
    assign busy     = (state != IDLE);
    assign lcd_rd_n = 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= RST_LO;
            cnt       <= '0;
            lcd_rst_n <= 1'b0;
            lcd_cs_n  <= 1'b1;
            lcd_wr_n  <= 1'b1;
            lcd_rs    <= 1'b0;
            lcd_db    <= '0;
            lcd_ready <= 1'b0;
        end else begin
            case (state)
                RST_LO: begin
                    if (cnt == RST_LO_LAST) begin
                        state     <= RST_WAIT;
                        cnt       <= '0;
                        lcd_rst_n <= 1'b1;
                    end else begin
                        cnt <= cnt + 24'd1;
                    end
                end
                RST_WAIT: begin
                    if (cnt == RST_WAIT_LAST) begin
                        state     <= IDLE;
                        cnt       <= '0;
                        lcd_ready <= 1'b1;
                    end else begin
                        cnt <= cnt + 24'd1;
                    end
                end
                IDLE: begin
                    if (!rempty) begin
                        state    <= WR_LO;
                        cnt      <= '0;
                        lcd_rs   <= rdata[16];
                        lcd_db   <= rdata[15:0];
                        lcd_cs_n <= 1'b0;
                        lcd_wr_n <= 1'b0;
                    end
                end
                WR_LO: begin
                    if (cnt == WR_LO_LAST) begin
                        state    <= WR_HI;
                        cnt      <= '0;
                        lcd_wr_n <= 1'b1;
                    end else begin
                        cnt <= cnt + 24'd1;
                    end
                end
                WR_HI: begin
                    if (cnt == WR_HI_LAST) begin
                        state    <= IDLE;
                        cnt      <= '0;
                        lcd_cs_n <= 1'b1;
                    end else begin
                        cnt <= cnt + 24'd1;
                    end
                end
                default: begin
                    state <= RST_LO;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule
